cp0_exc_unit: RTL

- Coprocessor-0 block directly downstream of the timer pair and the other bus peripherals. Consumes the six hardware interrupt lines (timer IRQ outputs on HWInt[0] and HWInt[1], the rest external) and pipeline exception codes.
- Holds SR, Cause, EPC and PRId.
- Asserts a single-cycle-evaluated interrupt/exception request that redirects the pipeline to the handler.
- Sits beside the M stage: mfc0/mtc0 access here, eret clears EXL here.

---
 rtl/cp0_exc_unit_pkg.sv | 36 +++
 rtl/cp0_exc_unit_if.sv | 26 ++
 rtl/cp0_exc_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and the handler entry address.
package cp0_exc_unit_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int unsigned SR_IE        = 0;
    localparam int unsigned SR_EXL       = 1;
    localparam int unsigned SR_IM_LO     = 10;
    localparam int unsigned SR_IM_HI     = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_BD     = 31;

    localparam logic [31:0] PRID_DEFAULT = 32'h0000_4350;
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    // EPC always holds a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline-side access bus of CP0: mfc0/mtc0, exception inputs, request out.
interface cp0_exc_unit_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] Dout;
    logic [31:0] EPC;
    logic        IntReq;
    logic [31:0] Handler;

    modport master (
        output A1, A2, Din, WE, PC, BD, ExcCode, HWInt, EXLClr,
        input  Dout, EPC, IntReq, Handler
    );

    modport slave (
        input  A1, A2, Din, WE, PC, BD, ExcCode, HWInt, EXLClr,
        output Dout, EPC, IntReq, Handler
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt/exception request and capture.
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID    = PRID_DEFAULT,
    parameter logic [31:0] HANDLER = HANDLER_ADDR
) (
    input logic            clk,
    input logic            reset,
    cp0_exc_unit_if.slave  bus
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        cause_bd;
    logic [5:0]  ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_pend;
    logic        exc_pend;
    logic        int_req;
    logic [31:0] victim_pc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Request terms; EXL masks both sources until eret.
    always_comb begin
        int_pend  = (|(bus.HWInt & im)) & ie & ~exl;
        exc_pend  = (bus.ExcCode != EXC_INT) & ~exl;
        int_req   = int_pend | exc_pend;
        victim_pc = bus.BD ? (bus.PC - 32'd4) : bus.PC;
    end

    // Architectural views of SR and Cause with unimplemented bits as zero.
    always_comb begin
        sr_word                          = '0;
        sr_word[SR_IM_HI:SR_IM_LO]       = im;
        sr_word[SR_EXL]                  = exl;
        sr_word[SR_IE]                   = ie;
        cause_word                       = '0;
        cause_word[CAUSE_BD]             = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    // mfc0 read mux; reads see pre-write state.
    always_comb begin
        bus.Dout = '0;
        case (bus.A1)
            REG_SR:    bus.Dout = sr_word;
            REG_CAUSE: bus.Dout = cause_word;
            REG_EPC:   bus.Dout = epc;
            REG_PRID:  bus.Dout = PRID;
            default:   bus.Dout = '0;
        endcase
    end

    assign bus.EPC     = epc;
    assign bus.IntReq  = int_req;
    assign bus.Handler = HANDLER;

    // State update: capture beats mtc0; eret clears EXL after any SR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            im        <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
            cause_bd  <= 1'b0;
            ip        <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            ip <= bus.HWInt;
            if (int_req) begin
                exl       <= 1'b1;
                cause_bd  <= bus.BD;
                cause_exc <= int_pend ? EXC_INT : bus.ExcCode;
                epc       <= word_align(victim_pc);
            end else begin
                if (bus.WE && bus.A2 == REG_SR) begin
                    im  <= bus.Din[SR_IM_HI:SR_IM_LO];
                    exl <= bus.Din[SR_EXL];
                    ie  <= bus.Din[SR_IE];
                end
                if (bus.WE && bus.A2 == REG_EPC) begin
                    epc <= word_align(bus.Din);
                end
                if (bus.EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

endmodule
